// File: rtl/demux_1x8_collect_if.sv
// ---------------------------------------------------------------------------
// demux_1x8_collect_if
// Bundle of the serial-in / parallel-out signals of demux_1x8_collect.
//   din, sel, s_valid, s_ready : serial bit input channel (slot select + data)
//   clr                        : synchronous abort of the partial word
//   out, m_valid, m_ready      : assembled 8-bit word output channel
//   fill_mask                  : slots already written in the current word
//   dup_err                    : one-cycle pulse on a duplicate-slot write
// Modport "master" is the collector itself (it drives the word and status);
// modport "slave" is the environment feeding bits and consuming words.
// ---------------------------------------------------------------------------
interface demux_1x8_collect_if;
  logic       din;
  logic [2:0] sel;
  logic       s_valid;
  logic       s_ready;
  logic       clr;
  logic [7:0] out;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] fill_mask;
  logic       dup_err;

  modport master (
    input  din, sel, s_valid, clr, m_ready,
    output s_ready, out, m_valid, fill_mask, dup_err
  );

  modport slave (
    output din, sel, s_valid, clr, m_ready,
    input  s_ready, out, m_valid, fill_mask, dup_err
  );
endinterface

// File: rtl/demux_1x8_collect.sv
// ---------------------------------------------------------------------------
// demux_1x8_collect
// Steers serial bits into one of eight slots selected by sel and presents the
// assembled byte once every slot has been written at least once.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : demux_1x8_collect_if.master (din/sel/s_valid/s_ready in,
//         out/m_valid/m_ready word out, clr abort, fill_mask, dup_err)
// Parameter:
//   ALLOW_OVERWRITE : 1 = a repeated slot replaces its stored bit,
//                     0 = a repeated slot keeps the first bit written.
// ---------------------------------------------------------------------------
module demux_1x8_collect #(
  parameter bit ALLOW_OVERWRITE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  demux_1x8_collect_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_mask;
  logic [7:0] r_asm;
  logic [7:0] r_out;
  logic       r_m_valid;
  logic       r_dup_err;

  logic       w_accept;
  logic       w_dup;
  logic       w_complete;
  logic [7:0] w_sel_onehot;
  logic [7:0] w_mask_next;
  logic [7:0] w_asm_next;

  // Ready depends only on state so that upstream never sees a path from m_ready.
  assign w_accept = bus.s_valid && (r_state != ST_HOLD);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign w_sel_onehot[gi] = (bus.sel == 3'(gi));
      // A slot takes din on its first write; repeats only when overwrite is on.
      assign w_asm_next[gi] =
        (w_accept && w_sel_onehot[gi] && (!r_mask[gi] || ALLOW_OVERWRITE))
          ? bus.din : r_asm[gi];
    end
  endgenerate

  assign w_dup       = w_accept && |(r_mask & w_sel_onehot);
  assign w_mask_next = r_mask | (w_accept ? w_sel_onehot : 8'h00);
  // Completion is on all eight distinct slots seen, not on a bit count;
  // a duplicate leaves the mask unchanged and so can never complete.
  assign w_complete  = w_accept && (w_mask_next == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mask    <= 8'h00;
      r_asm     <= 8'h00;
      r_out     <= 8'h00;
      r_m_valid <= 1'b0;
      r_dup_err <= 1'b0;
    end else begin
      r_dup_err <= 1'b0;
      if (bus.clr) begin
        // Abort wins over everything; the presented bit is dropped and the
        // last delivered word stays visible on out.
        r_state   <= ST_IDLE;
        r_mask    <= 8'h00;
        r_m_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_COLLECT: begin
            if (w_accept) begin
              r_mask    <= w_mask_next;
              r_asm     <= w_asm_next;
              r_dup_err <= w_dup;
              if (w_complete) begin
                r_out     <= w_asm_next;
                r_m_valid <= 1'b1;
                r_state   <= ST_HOLD;
              end else begin
                r_state   <= ST_COLLECT;
              end
            end
          end
          ST_HOLD: begin
            if (bus.m_ready) begin
              r_m_valid <= 1'b0;
              r_mask    <= 8'h00;
              r_state   <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.s_ready   = (r_state != ST_HOLD);
  assign bus.out       = r_out;
  assign bus.m_valid   = r_m_valid;
  assign bus.fill_mask = r_mask;
  assign bus.dup_err   = r_dup_err;

endmodule

// File: tb/tb_demux_1x8_collect.sv
// ---------------------------------------------------------------------------
// tb_demux_1x8_collect
// Drives one stimulus stream into two collectors (overwrite on / off) and
// checks both against a slot-level model every negative clock edge, plus
// hand-computed literal expectations at key points of each scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_1x8_collect;

  logic       clk;
  logic       rst;
  logic       t_din;
  logic [2:0] t_sel;
  logic       t_s_valid;
  logic       t_clr;
  logic       t_m_ready;

  demux_1x8_collect_if if0 ();
  demux_1x8_collect_if if1 ();

  assign if0.din = t_din;  assign if0.sel = t_sel;  assign if0.s_valid = t_s_valid;
  assign if0.clr = t_clr;  assign if0.m_ready = t_m_ready;
  assign if1.din = t_din;  assign if1.sel = t_sel;  assign if1.s_valid = t_s_valid;
  assign if1.clr = t_clr;  assign if1.m_ready = t_m_ready;

  demux_1x8_collect #(.ALLOW_OVERWRITE(1'b1)) u_dut_ow (.clk(clk), .rst(rst), .bus(if0));
  demux_1x8_collect #(.ALLOW_OVERWRITE(1'b0)) u_dut_keep (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: per DUT, which slots are filled and with what ----
  // index 0 = overwrite allowed, index 1 = first write kept
  bit   md_have [2][8];
  bit   md_val  [2][8];
  logic [7:0] md_out [2];
  bit   md_hold [2];
  bit   md_dup  [2];

  function automatic int count_have(input int k);
    int n = 0;
    for (int i = 0; i < 8; i++) n += md_have[k][i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [7:0] word_with(input int k, input int s, input bit d);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = md_val[k][i];
    w[s] = d;
    return w;
  endfunction

  function automatic logic [7:0] mask_of(input int k);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = md_have[k][i];
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) md_have[k][i] <= 1'b0;
        md_out[k]  <= 8'h00;
        md_hold[k] <= 1'b0;
        md_dup[k]  <= 1'b0;
      end else begin
        md_dup[k] <= 1'b0;
        if (t_clr) begin
          for (int i = 0; i < 8; i++) md_have[k][i] <= 1'b0;
          md_hold[k] <= 1'b0;
        end else if (md_hold[k]) begin
          if (t_m_ready) begin
            for (int i = 0; i < 8; i++) md_have[k][i] <= 1'b0;
            md_hold[k] <= 1'b0;
          end
        end else if (t_s_valid) begin
          if (md_have[k][t_sel]) begin
            md_dup[k] <= 1'b1;
            if (k == 0) md_val[k][t_sel] <= t_din;
          end else begin
            md_have[k][t_sel] <= 1'b1;
            md_val[k][t_sel]  <= t_din;
            if (count_have(k) == 7) begin
              md_out[k]  <= word_with(k, int'(t_sel), t_din);
              md_hold[k] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec;
  int n_mis;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ow.out",       if0.out,              md_out[0]);
    chk("ow.m_valid",   8'(if0.m_valid),      8'(md_hold[0]));
    chk("ow.s_ready",   8'(if0.s_ready),      8'(!md_hold[0]));
    chk("ow.fill_mask", if0.fill_mask,        mask_of(0));
    chk("ow.dup_err",   8'(if0.dup_err),      8'(md_dup[0]));
    chk("kp.out",       if1.out,              md_out[1]);
    chk("kp.m_valid",   8'(if1.m_valid),      8'(md_hold[1]));
    chk("kp.s_ready",   8'(if1.s_ready),      8'(!md_hold[1]));
    chk("kp.fill_mask", if1.fill_mask,        mask_of(1));
    chk("kp.dup_err",   8'(if1.dup_err),      8'(md_dup[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [2:0] s, input bit d,
                        input bit c, input bit mr);
    t_s_valid = v; t_sel = s; t_din = d; t_clr = c; t_m_ready = mr;
  endtask

  // Write all eight slots in order 0..7 with the bits of w.
  task automatic fill_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 3'(i), w[i], 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_word();
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    #23 rst = 1'b0;
    #1;
    chk("rst.out",     if0.out,            8'h00);
    chk("rst.s_ready", 8'(if0.s_ready),    8'h01);
    chk("rst.mask",    if0.fill_mask,      8'h00);

    // In-order fill: din 1,0,1,1,0,0,1,0 on slots 0..7 -> 8'h4D.
    @(negedge clk); #1;
    fill_word(8'h4D);
    chk("inorder.out",     if0.out,         8'h4D);
    chk("inorder.m_valid", 8'(if0.m_valid), 8'h01);
    chk("inorder.s_ready", 8'(if0.s_ready), 8'h00);
    tick();
    chk("inorder.hold_out", if0.out,        8'h4D);
    release_word();
    chk("inorder.rel_valid", 8'(if0.m_valid), 8'h00);
    chk("inorder.rel_mask",  if0.fill_mask,   8'h00);

    // Reverse fill of all ones, then a bit offered while held.
    for (int i = 7; i >= 0; i--) begin
      set_in(1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("reverse.out",  if0.out, 8'hFF);
    set_in(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reverse.ignored_out", if0.out,          8'hFF);
    chk("reverse.ignored_dup", 8'(if0.dup_err),  8'h00);
    chk("reverse.ignored_mask", if0.fill_mask,   8'hFF);
    release_word();

    // Duplicate on slot 3: 1 then 0.
    set_in(1'b1, 3'd3, 1'b1, 1'b0, 1'b0); tick();
    set_in(1'b1, 3'd3, 1'b0, 1'b0, 1'b0); tick();
    chk("dup.pulse_ow",   8'(if0.dup_err), 8'h01);
    chk("dup.pulse_kp",   8'(if1.dup_err), 8'h01);
    chk("dup.mask",       if0.fill_mask,   8'h08);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("dup.pulse_end",  8'(if0.dup_err), 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        set_in(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
        tick();
      end
    end
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("dup.out_ow", if0.out, 8'h00);
    chk("dup.out_kp", if1.out, 8'h08);
    release_word();

    // Abort after 5 slots, with a duplicate-slot bit offered on the clr edge.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("abort.pre_mask", if0.fill_mask, 8'h1F);
    set_in(1'b1, 3'd0, 1'b1, 1'b1, 1'b0); tick();
    chk("abort.mask",    if0.fill_mask,   8'h00);
    chk("abort.dup",     8'(if0.dup_err), 8'h00);
    chk("abort.m_valid", 8'(if0.m_valid), 8'h00);
    chk("abort.out",     if0.out,         8'h00);
    set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    fill_word(8'h3C);
    chk("abort.refill", if0.out, 8'h3C);
    release_word();

    // Asynchronous reset while holding 8'hA5.
    fill_word(8'hA5);
    chk("rstmid.hold", if0.out, 8'hA5);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.out",     if0.out,          8'h00);
    chk("rstmid.m_valid", 8'(if0.m_valid),  8'h00);
    chk("rstmid.mask",    if0.fill_mask,    8'h00);
    chk("rstmid.kp_out",  if1.out,          8'h00);
    tick();
    #3 rst = 1'b0;
    fill_word(8'h5A);
    chk("rstmid.refill", if0.out, 8'h5A);
    release_word();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/demux_1x8_collect.md
DEMUX_1X8_COLLECT -- requirements
Module: demux_1x8_collect

Interface
REQ-001 Parameter: ALLOW_OVERWRITE, default 1; 1 = a duplicate-slot write replaces the stored bit, 0 = duplicate-slot data is discarded.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  1  serial data bit to be steered into a slot.
REQ-006 sel  input  3  destination slot index for din: 0 = bit 0 … 7 = bit 7.
REQ-007 s_valid  input  1  din/sel are valid this cycle.
REQ-008 s_ready  output  1  block accepts din/sel this cycle.
REQ-009 clr  input  1  synchronous abort of the partial word.
REQ-010 out  output  8  assembled parallel word, registered.
REQ-011 m_valid  output  1  out holds a complete word.
REQ-012 m_ready  input  1  downstream consumes out.
REQ-013 fill_mask  output  8  slots written in the current word; bit i = slot i.
REQ-014 dup_err  output  1  one-cycle pulse on a duplicate-slot write.

Function
REQ-015 Accept: a bit SHALL be accepted on a rising edge where s_valid=1 and s_ready=1.
REQ-016 Steering: an accepted bit SHALL set fill_mask[sel].
  - Mask bit previously 0: assembly bit [sel] <= din.
REQ-017 Duplicate: an accepted bit with fill_mask[sel] already 1 SHALL pulse dup_err high for exactly the following cycle.
  - Mask unchanged.
  - Data overwritten only if ALLOW_OVERWRITE=1.
REQ-018 FSM states: IDLE (mask=00), COLLECT (mask nonzero and not FF), HOLD (word presented).
REQ-019 IDLE -> COLLECT on the first accept; COLLECT -> HOLD on the accept that makes the mask FF.
REQ-020 Completion latency: on the completing edge, out SHALL load the full assembled word (including that bit).
  - m_valid=1 from the next cycle.
  - Zero bubbles.
REQ-021 HOLD: out and m_valid SHALL stay stable until the edge where m_ready=1.
  - On that edge: m_valid<=0, mask<=00, state<=IDLE.
REQ-022 s_ready SHALL be 1 in IDLE and COLLECT, and 0 in HOLD.
  - s_ready is combinational from state only; it does not depend on m_ready.
REQ-023 Inputs present while s_ready=0 SHALL be ignored: no mask, data or dup_err effect.
REQ-024 clr=1 SHALL take priority over all other inputs on that edge.
  - mask<=00, m_valid<=0, state<=IDLE, out unchanged, no dup_err.
  - Any bit presented that cycle is dropped.
REQ-025 A mask of FF SHALL exist only in HOLD.
  - Slots may arrive in any order; completion is on distinct-slot count = 8, not on accept count.
REQ-026 out SHALL change only on a completing edge or on reset.

Reset
REQ-027 Reset SHALL act asynchronously, whether asserted idle or mid-word.
  - out=00, m_valid=0, fill_mask=00, dup_err=0, state IDLE; s_ready=1 after deassertion.
  - A partial word is discarded.
REQ-028 The first edge after rst deassertion SHALL accept normally.

Verification
REQ-029 In-order fill: sel 0..7 with din 1,0,1,1,0,0,1,0, back-to-back, m_ready=0.
  - m_valid=1 the cycle after the 8th accept; out=8'h4D; s_ready=0.
  - Then m_ready=1 for 1 cycle -> m_valid=0, fill_mask=00.
REQ-030 Reverse fill: sel 7..0 with din all 1, then 1 bit on slot 0 with din 0.
  - After the 8th accept: out=8'hFF; the 9th bit is not accepted (s_ready=0) and out stays FF.
REQ-031 Duplicate: slot 3 written din=1 then din=0, ALLOW_OVERWRITE=1.
  - dup_err pulses 1 cycle; fill_mask=8'h08; after the other 7 slots are written with 0, out=8'h00.
  - With ALLOW_OVERWRITE=0 and the same stimulus, out=8'h08.
REQ-032 Abort: 5 slots written, then clr=1 with s_valid=1 on the same edge.
  - fill_mask=00, m_valid=0, no dup_err; a fresh 8-slot fill then completes normally.
REQ-033 Reset mid-operation: assert rst asynchronously in HOLD (out=8'hA5), between clock edges.
  - out=00, m_valid=0, fill_mask=00 immediately; after release, an 8-slot fill gives the correct word.
